register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the data width of every register and data port.
REQ-002 The block SHALL have port clock, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-004 The block SHALL have port read_reg_0, input, 5 bits; read port 0 register index.
REQ-005 The block SHALL have port read_reg_1, input, 5 bits; read port 1 register index.
REQ-006 The block SHALL have port write_reg, input, 5 bits; write port register index.
REQ-007 The block SHALL have port write_data, input, XLEN bits; write port data.
REQ-008 The block SHALL have port write_enable, input, 1 bit; commits write_data to write_reg on the next rising clock edge.
REQ-009 The block SHALL have port read_data_0, output, XLEN bits; contents of read_reg_0.
REQ-010 The block SHALL have port read_data_1, output, XLEN bits; contents of read_reg_1.
REQ-011 Ports SHALL be declared in the order read_reg_0, read_reg_1, write_reg, write_data, write_enable, read_data_0, read_data_1, clock, reset, to support positional instantiation.

Function
REQ-012 The block SHALL hold 32 registers x0..x31, each XLEN bits wide.
REQ-013 A write SHALL occur on the rising clock edge when write_enable=1 and reset=1; write_data is stored into register write_reg.
REQ-014 When write_enable=0, no register SHALL change.
REQ-015 Register x0 SHALL be hardwired to zero: writes to index 0 are discarded, and reads of index 0 return 0.
REQ-016 Reads SHALL be combinational with zero-cycle latency: read_data_N follows read_reg_N and the register contents without a clock edge.
REQ-017 Both read ports SHALL be independent and may address the same register simultaneously, including write_reg.
REQ-018 Without the bypass feature (REQ-023), a read of write_reg in the cycle of a write SHALL return the old value until the clock edge, and the new value after it.
REQ-019 Outputs SHALL never be X or Z once reset has been applied.

Reset
REQ-020 Asserting reset=0 SHALL immediately clear all registers to 0, independent of clock.
REQ-021 While reset=0, writes SHALL be ignored and both read outputs SHALL read 0.
REQ-022 Deasserting reset SHALL have no effect on state until the next qualifying clock edge; a reset asserted mid-write SHALL win, leaving the register at 0.

Configuration
REQ-023 When the macro REGFILE_BYPASS_EN is defined, a read port whose index equals write_reg (nonzero) while write_enable=1 SHALL return write_data combinationally (write-through); without the macro, REQ-018 SHALL apply.
REQ-024 Bypass SHALL never apply to x0 or while reset=0.

Structure
REQ-025 A shared package regfile_pkg SHALL hold constants XLEN_DEFAULT=32, NUM_REGS=32, and REG_ADDR_W=5, plus the register-index typedef.
REQ-026 A sub-module regfile_read_port SHALL implement the read mux, x0 masking, and optional bypass, and SHALL be instantiated twice.

Verification
REQ-027 The bench SHALL pulse reset=0, then release it; both read ports SHALL read 0 for every index.
REQ-028 The bench SHALL write 32-i to index i for i=0..31, one write per clock, then read pairs (i, i+1); read_data SHALL equal 32-i for i≥1 and 0 for index 0.
REQ-029 The bench SHALL hold write_enable=0 with write_reg=5 and write_data=0xDEADBEEF across a clock edge; x5 SHALL be unchanged.
REQ-030 The bench SHALL set read_reg_0=read_reg_1=7 after writing 0x12345678 to x7; both outputs SHALL read 0x12345678.
REQ-031 The bench SHALL write 0xA5A5A5A5 to x3 while reading x3 before the edge; the read SHALL return the old value without REGFILE_BYPASS_EN and 0xA5A5A5A5 with it.
REQ-032 The bench SHALL assert reset asynchronously between clock edges after loading nonzero values; all reads SHALL be 0 immediately, before any clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, x0 masking, optional write-through bypass.
// Latency: zero cycles, purely combinational from index/storage/write inputs to read_data.
// Backpressure: none; the port is always ready.
//
// Optional feature: REGFILE_BYPASS_EN returns write_data when the read index matches a
// nonzero write_reg with write_enable=1 and reset released.
//
// Ports:
//   regs_flat    - all registers concatenated, register i at [i*XLEN +: XLEN]
//   reset        - active-low reset; forces read_data to zero while low
//   write_enable, write_reg, write_data - pending write, used only for bypass
//   read_reg     - register index to read
//   read_data    - selected register contents
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [NUM_REGS*XLEN-1:0] regs_flat,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [REG_ADDR_W-1:0]    write_reg,
    input  logic [XLEN-1:0]          write_data,
    input  logic [REG_ADDR_W-1:0]    read_reg,
    output logic [XLEN-1:0]          read_data
);

    reg_idx_t idx;
    assign idx = reg_idx_t'(read_reg);

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;
    // x0 and the reset state are excluded so the hardwired zero is never overridden.
    assign bypass_hit = write_enable && (write_reg == idx) && (idx != '0);
`else
    logic unused_bypass;
    assign unused_bypass = ^{write_enable, write_reg, write_data};
`endif

    always_comb begin
        read_data = '0;
        if (!reset || idx == '0) begin
            read_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (bypass_hit) begin
            read_data = write_data;
        end
`endif
        else begin
            read_data = regs_flat[idx*XLEN +: XLEN];
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 32 x XLEN register file, two combinational read ports, one clocked write port, x0 hardwired to 0.
// Latency: reads zero cycles; writes visible after the next rising clock edge.
// Backpressure: none; a write is accepted on every edge with write_enable=1.
//
// Optional feature: define REGFILE_BYPASS_EN for write-through reads of the register being written.
//
// Ports:
//   read_reg_0/1  - read indices          read_data_0/1 - read results
//   write_reg     - write index           write_data    - write value
//   write_enable  - commit write on the rising edge of clock
//   clock         - single clock          reset         - asynchronous, active-low
module register_file
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] read_reg_0,
    input  logic [REG_ADDR_W-1:0] read_reg_1,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [XLEN-1:0]       write_data,
    input  logic                  write_enable,
    output logic [XLEN-1:0]       read_data_0,
    output logic [XLEN-1:0]       read_data_1,
    input  logic                  clock,
    input  logic                  reset
);

    // x0 has no storage; it is a constant zero slot in the flattened view.
    logic [XLEN-1:0]          regs [1:NUM_REGS-1];
    logic [NUM_REGS*XLEN-1:0] regs_flat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && write_reg != '0) begin
            regs[write_reg] <= write_data;
        end
    end

    assign regs_flat[XLEN-1:0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*XLEN +: XLEN] = regs[g];
    end

    regfile_read_port #(.XLEN(XLEN)) u_read_port_0 (
        .regs_flat    (regs_flat),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg     (read_reg_0),
        .read_data    (read_data_0)
    );

    regfile_read_port #(.XLEN(XLEN)) u_read_port_1 (
        .regs_flat    (regs_flat),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg     (read_reg_1),
        .read_data    (read_data_1)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps plus random traffic against an array model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_register_file;

    logic [4:0]  read_reg_0;
    logic [4:0]  read_reg_1;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data_0;
    logic [31:0] read_data_1;
    logic        clock;
    logic        reset;

    int checks   = 0;
    int failures = 0;

    // Architectural view of the registers: what each x[i] should hold.
    logic [31:0] model [32];

    register_file dut (
        .read_reg_0   (read_reg_0),
        .read_reg_1   (read_reg_1),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data_0  (read_data_0),
        .read_data_1  (read_data_1),
        .clock        (clock),
        .reset        (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a read of idx should show right now, given the model and the current inputs.
    function automatic logic [31:0] expect_rd(input logic [4:0] idx);
        if (!reset || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (write_enable && idx == write_reg) return write_data;
`endif
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One rising edge: apply the architectural write rule to the model, then
    // land just after the falling edge where inputs are changed and outputs sampled.
    task automatic tick();
        @(posedge clock);
        if (reset && write_enable && write_reg != 5'd0) model[write_reg] = write_data;
        @(negedge clock);
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_rd0"}, read_data_0, expect_rd(read_reg_0));
        check({tag, "_rd1"}, read_data_1, expect_rd(read_reg_1));
    endtask

    initial begin
        clear_model();
        reset        = 1'b0;
        write_enable = 1'b1;
        write_reg    = 5'd4;
        write_data   = 32'hFFFF_FFFF;
        read_reg_0   = 5'd4;
        read_reg_1   = 5'd0;

        // Held in reset across edges with a write pending: the write must be ignored.
        tick();
        tick();
        check("in_reset_rd0", read_data_0, 32'd0);
        check("in_reset_rd1", read_data_1, 32'd0);

        reset        = 1'b1;
        write_enable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg_0 = 5'(i);
            read_reg_1 = 5'(31 - i);
            #1;
            check("post_reset_rd0", read_data_0, 32'd0);
            check("post_reset_rd1", read_data_1, 32'd0);
        end

        // Fill: x[i] = 32 - i, one write per clock; the x0 write is discarded.
        write_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            write_reg  = 5'(i);
            write_data = 32'(32 - i);
            tick();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 31; i++) begin
            read_reg_0 = 5'(i);
            read_reg_1 = 5'(i + 1);
            #1;
            check("fill_rd0", read_data_0, (i == 0) ? 32'd0 : 32'(32 - i));
            check("fill_rd1", read_data_1, 32'(31 - i));
        end

        // Disabled write must not touch x5.
        write_enable = 1'b0;
        write_reg    = 5'd5;
        write_data   = 32'hDEAD_BEEF;
        tick();
        read_reg_0 = 5'd5;
        read_reg_1 = 5'd5;
        #1;
        check("we0_x5", read_data_0, 32'd27);

        // Both ports on the same register.
        write_enable = 1'b1;
        write_reg    = 5'd7;
        write_data   = 32'h1234_5678;
        tick();
        write_enable = 1'b0;
        read_reg_0   = 5'd7;
        read_reg_1   = 5'd7;
        #1;
        check("same_rd0", read_data_0, 32'h1234_5678);
        check("same_rd1", read_data_1, 32'h1234_5678);

        // Read of the register being written, before and after the edge.
        write_enable = 1'b1;
        write_reg    = 5'd3;
        write_data   = 32'hA5A5_A5A5;
        read_reg_0   = 5'd3;
        read_reg_1   = 5'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_before_edge", read_data_0, 32'hA5A5_A5A5);
`else
        check("rw_before_edge", read_data_0, 32'd29);
`endif
        check("rw_other_port", read_data_1, 32'd30);
        tick();
        write_enable = 1'b0;
        #1;
        check("rw_after_edge", read_data_0, 32'hA5A5_A5A5);

        // Writing x0 with a read of x0 in flight: never bypassed, never stored.
        write_enable = 1'b1;
        write_reg    = 5'd0;
        write_data   = 32'hCAFE_F00D;
        read_reg_0   = 5'd0;
        read_reg_1   = 5'd0;
        check_ports("x0_write");
        check("x0_before", read_data_0, 32'd0);
        tick();
        write_enable = 1'b0;
        #1;
        check("x0_after", read_data_1, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            write_enable = 1'($urandom_range(0, 1));
            write_reg    = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            read_reg_0   = 5'($urandom_range(0, 31));
            read_reg_1   = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            check_ports("rand");
            tick();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg_0 = 5'(i);
            read_reg_1 = 5'(i);
            check_ports("rand_final");
        end

        // Asynchronous reset mid-cycle with a write pending: reset wins, outputs drop at once.
        write_enable = 1'b1;
        write_reg    = 5'd9;
        write_data   = 32'h0BAD_0BAD;
        read_reg_0   = 5'd9;
        read_reg_1   = 5'd7;
        #1;
        check("pre_async_x7", read_data_1, model[7]);
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        check("async_rd0", read_data_0, 32'd0);
        check("async_rd1", read_data_1, 32'd0);
        tick();
        write_enable = 1'b0;
        reset        = 1'b1;
        #1;
        check("after_rst_x9", read_data_0, 32'd0);
        check("after_rst_x7", read_data_1, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_reg_0 = 5'(i);
            read_reg_1 = 5'(31 - i);
            check_ports("after_rst_all");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_register_file
